// File: rtl/xgmii_link_fault_rs.sv
// Per-channel XGMII link fault sequence detection and RS fault signalling toward the PHY.
// Define XGMII_FAULT_STATS_EN to build the per-channel fault event counters (fault_cnt).
module xgmii_link_fault_rs #(
  parameter int NUM_CH     = 1,
  parameter int COL_WINDOW = 128,
  parameter int SEQ_THRESH = 4
) (
  input  logic                  xgmii_tx_clk,
  input  logic                  xgmii_tx_clk_reset,
  input  logic [72*NUM_CH-1:0]  rx_dc_in,
  input  logic [72*NUM_CH-1:0]  tx_dc_in,
  output logic [72*NUM_CH-1:0]  tx_dc_out,
  output logic [2*NUM_CH-1:0]   link_fault,
  output logic [16*NUM_CH-1:0]  fault_cnt,
  input  logic                  fault_cnt_clr
);

  typedef enum logic [1:0] {
    FAULT_OK     = 2'b00,
    FAULT_LOCAL  = 2'b01,
    FAULT_REMOTE = 2'b10
  } fault_e;

  localparam int              CW        = $clog2(COL_WINDOW + 1);
  localparam logic [CW-1:0]   COL_MAX   = CW'(COL_WINDOW);
  localparam logic [3:0]      SEQ_MIN   = 4'(SEQ_THRESH);
  localparam logic [35:0]     RF_COL    = {9'h002, 9'h000, 9'h000, 9'h19C};
  localparam logic [71:0]     RF_WORD   = {RF_COL, RF_COL};
  localparam logic [71:0]     IDLE_WORD = {8{9'h107}};

`ifndef XGMII_FAULT_STATS_EN
  logic unused_clr;
  assign unused_clr = fault_cnt_clr;
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    fault_e        last_q, last_d, fault_q, fault_d, typ;
    logic [3:0]    seq_q, seq_d;
    logic [CW-1:0] col_q, col_d;
    logic [71:0]   rx_w, tx_w, tx_q;
    logic [35:0]   col;
    logic          is_seq;

    assign rx_w = rx_dc_in[72*ch +: 72];
    assign tx_w = tx_dc_in[72*ch +: 72];

    // Walk both columns in time order; a later column's event overrides an earlier one.
    always_comb begin
      last_d  = last_q;
      seq_d   = seq_q;
      col_d   = col_q;
      fault_d = fault_q;
      col     = '0;
      is_seq  = 1'b0;
      typ     = FAULT_LOCAL;
      for (int c = 0; c < 2; c++) begin
        col    = rx_w[36*c +: 36];
        is_seq = (col[8:0] == 9'h19C) && (col[26:9] == 18'h0) &&
                 ((col[35:27] == 9'h001) || (col[35:27] == 9'h002));
        typ    = col[28] ? FAULT_REMOTE : FAULT_LOCAL;
        if (is_seq) begin
          col_d = '0;
          if (typ == last_d) begin
            if (seq_d != 4'hF) seq_d = seq_d + 4'd1;
          end else begin
            last_d = typ;
            seq_d  = 4'd1;
          end
          if (seq_d >= SEQ_MIN) fault_d = last_d;
        end else begin
          if (col_d != COL_MAX) col_d = col_d + 1'b1;
          if (col_d == COL_MAX) begin
            fault_d = FAULT_OK;
            seq_d   = '0;
          end
        end
      end
    end

    always_ff @(posedge xgmii_tx_clk or posedge xgmii_tx_clk_reset) begin
      if (xgmii_tx_clk_reset) begin
        last_q  <= FAULT_LOCAL;
        seq_q   <= '0;
        col_q   <= '0;
        fault_q <= FAULT_OK;
        tx_q    <= IDLE_WORD;
      end else begin
        last_q  <= last_d;
        seq_q   <= seq_d;
        col_q   <= col_d;
        fault_q <= fault_d;
        case (fault_q)
          FAULT_LOCAL:  tx_q <= RF_WORD;
          FAULT_REMOTE: tx_q <= IDLE_WORD;
          default:      tx_q <= tx_w;
        endcase
      end
    end

    assign tx_dc_out[72*ch +: 72] = tx_q;
    assign link_fault[2*ch +: 2]  = fault_q;

`ifdef XGMII_FAULT_STATS_EN
    logic [15:0] cnt_q;

    // An episode is counted once, when the channel leaves OK; clear wins over a new episode.
    always_ff @(posedge xgmii_tx_clk or posedge xgmii_tx_clk_reset) begin
      if (xgmii_tx_clk_reset) begin
        cnt_q <= '0;
      end else if (fault_cnt_clr) begin
        cnt_q <= '0;
      end else if ((fault_q == FAULT_OK) && (fault_d != FAULT_OK) && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end

    assign fault_cnt[16*ch +: 16] = cnt_q;
`else
    assign fault_cnt[16*ch +: 16] = 16'h0000;
`endif
  end

endmodule

// File: tb/tb_xgmii_link_fault_rs.sv
// Self-checking bench for xgmii_link_fault_rs (NUM_CH=4): directed scenarios plus randomized
// per-channel traffic compared every cycle against a column-by-column reference model.
module tb_xgmii_link_fault_rs;

  localparam int NCH        = 4;
  localparam int COL_WINDOW = 128;
  localparam int SEQ_THRESH = 4;

  localparam logic [35:0] LF_COL   = {9'h001, 9'h000, 9'h000, 9'h19C};
  localparam logic [35:0] RF_COL   = {9'h002, 9'h000, 9'h000, 9'h19C};
  localparam logic [35:0] IDLE_COL = {4{9'h107}};
  localparam logic [71:0] LF2      = {LF_COL, LF_COL};
  localparam logic [71:0] RF2      = {RF_COL, RF_COL};
  localparam logic [71:0] IDLE2    = {IDLE_COL, IDLE_COL};

  logic         clk;
  logic         rst;
  logic [287:0] rx_dc_in;
  logic [287:0] tx_dc_in;
  logic [287:0] tx_dc_out;
  logic [7:0]   link_fault;
  logic [63:0]  fault_cnt;
  logic         fault_cnt_clr;

  int checks   = 0;
  int failures = 0;

  int          m_last  [NCH];
  int          m_seq   [NCH];
  int          m_col   [NCH];
  int          m_fault [NCH];
  int          m_cnt   [NCH];
  logic [71:0] m_tx    [NCH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xgmii_link_fault_rs #(
    .NUM_CH     (NCH),
    .COL_WINDOW (COL_WINDOW),
    .SEQ_THRESH (SEQ_THRESH)
  ) dut (
    .xgmii_tx_clk       (clk),
    .xgmii_tx_clk_reset (rst),
    .rx_dc_in           (rx_dc_in),
    .tx_dc_in           (tx_dc_in),
    .tx_dc_out          (tx_dc_out),
    .link_fault         (link_fault),
    .fault_cnt          (fault_cnt),
    .fault_cnt_clr      (fault_cnt_clr)
  );

  task automatic checkOutput(input string tag, input logic [287:0] observed, input logic [287:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [287:0] all_ch(input logic [71:0] w);
    return {4{w}};
  endfunction

  function automatic logic [287:0] one_ch(input int ch, input logic [71:0] w);
    logic [287:0] v;
    v = {4{IDLE2}};
    v[72*ch +: 72] = w;
    return v;
  endfunction

  function automatic logic [287:0] rand_bits();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // 0 = not a sequence ordered set, 1 = local fault, 2 = remote fault
  function automatic int col_kind(input logic [35:0] c);
    if (c[8:0] != 9'h19C || c[17:9] != 9'h000 || c[26:18] != 9'h000) return 0;
    if (c[35:27] == 9'h001) return 1;
    if (c[35:27] == 9'h002) return 2;
    return 0;
  endfunction

  function automatic logic [35:0] rand_col(input int mode);
    int r, idx;
    logic [35:0] c;
    r = $urandom_range(0, 99);
    case (mode)
      1: if (r < 80) return LF_COL;
      2: if (r < 80) return RF_COL;
      3: begin
        if (r < 33) return LF_COL;
        if (r < 66) return RF_COL;
      end
      default: begin
        if (r < 3) return LF_COL;
        if (r < 6) return RF_COL;
      end
    endcase
    case ($urandom_range(0, 2))
      0: c = IDLE_COL;
      1: c = {1'b0, 8'($urandom), 1'b0, 8'($urandom), 1'b0, 8'($urandom), 1'b0, 8'($urandom)};
      default: begin
        c   = ($urandom_range(0, 1) != 0) ? LF_COL : RF_COL;
        idx = $urandom_range(0, 35);
        c[idx] = ~c[idx];
      end
    endcase
    return c;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_last[ch]  = 1;
      m_seq[ch]   = 0;
      m_col[ch]   = 0;
      m_fault[ch] = 0;
      m_cnt[ch]   = 0;
      m_tx[ch]    = IDLE2;
    end
  endtask

  task automatic model_step(input logic [287:0] rx, input logic [287:0] tx, input logic clr);
    int kind, nf;
    for (int ch = 0; ch < NCH; ch++) begin
      case (m_fault[ch])
        1:       m_tx[ch] = RF2;
        2:       m_tx[ch] = IDLE2;
        default: m_tx[ch] = tx[72*ch +: 72];
      endcase
      nf = m_fault[ch];
      for (int c = 0; c < 2; c++) begin
        kind = col_kind(rx[72*ch + 36*c +: 36]);
        if (kind != 0) begin
          m_col[ch] = 0;
          if (kind == m_last[ch]) begin
            m_seq[ch] = (m_seq[ch] < 15) ? m_seq[ch] + 1 : 15;
          end else begin
            m_last[ch] = kind;
            m_seq[ch]  = 1;
          end
          if (m_seq[ch] >= SEQ_THRESH) nf = m_last[ch];
        end else begin
          m_col[ch] = (m_col[ch] < COL_WINDOW) ? m_col[ch] + 1 : COL_WINDOW;
          if (m_col[ch] == COL_WINDOW) begin
            nf        = 0;
            m_seq[ch] = 0;
          end
        end
      end
      if (clr) m_cnt[ch] = 0;
      else if (m_fault[ch] == 0 && nf != 0 && m_cnt[ch] < 65535) m_cnt[ch]++;
      m_fault[ch] = nf;
    end
  endtask

  task automatic applyStimulus(input logic [287:0] rx, input logic [287:0] tx, input logic clr);
    logic [287:0] etx;
    logic [7:0]   elf;
    logic [63:0]  ecnt;
    rx_dc_in      = rx;
    tx_dc_in      = tx;
    fault_cnt_clr = clr;
    @(posedge clk);
    #1;
    model_step(rx, tx, clr);
    for (int ch = 0; ch < NCH; ch++) begin
      etx[72*ch +: 72] = m_tx[ch];
      elf[2*ch +: 2]   = 2'(m_fault[ch]);
`ifdef XGMII_FAULT_STATS_EN
      ecnt[16*ch +: 16] = 16'(m_cnt[ch]);
`else
      ecnt[16*ch +: 16] = 16'h0000;
`endif
    end
    checkOutput("tx_dc_out", tx_dc_out, etx);
    checkOutput("link_fault", 288'(link_fault), 288'(elf));
    checkOutput("fault_cnt", 288'(fault_cnt), 288'(ecnt));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(all_ch(IDLE2), rand_bits(), 1'b0);
  endtask

  task automatic doReset();
    rx_dc_in      = all_ch(LF2);
    tx_dc_in      = rand_bits();
    fault_cnt_clr = 1'b0;
    rst           = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_link_fault", 288'(link_fault), 288'(8'h00));
      checkOutput("rst_tx_dc_out", tx_dc_out, all_ch(IDLE2));
      checkOutput("rst_fault_cnt", 288'(fault_cnt), 288'(64'h0));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [287:0] data;
    logic [287:0] rnd_rx;
    logic [15:0]  exp_cnt;
    int           mode [NCH];
    int           dur  [NCH];

    rst           = 1'b0;
    rx_dc_in      = '0;
    tx_dc_in      = '0;
    fault_cnt_clr = 1'b0;
    #2;
    doReset();

    $display("[TB] local fault declaration and RS response");
    applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
    checkOutput("req028_below", 288'(link_fault), 288'(8'h00));
    applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
    checkOutput("req028_lf", 288'(link_fault), 288'(8'h01));
    applyStimulus(all_ch(IDLE2), rand_bits(), 1'b0);
    checkOutput("req028_tx", 288'(tx_dc_out[71:0]), 288'(RF2));

    $display("[TB] interleaved types then remote fault");
    applyStimulus(one_ch(0, RF2), rand_bits(), 1'b0);
    applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
    checkOutput("req029_hold", 288'(link_fault), 288'(8'h01));
    applyStimulus(one_ch(0, RF2), rand_bits(), 1'b0);
    applyStimulus(one_ch(0, RF2), rand_bits(), 1'b0);
    checkOutput("req029_rf", 288'(link_fault), 288'(8'h02));
    applyStimulus(all_ch(IDLE2), rand_bits(), 1'b0);
    checkOutput("req029_tx", 288'(tx_dc_out[71:0]), 288'(IDLE2));

    $display("[TB] column window expiry");
    applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
    applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
    checkOutput("req030_lf", 288'(link_fault), 288'(8'h01));
    idleCycles(63);
    checkOutput("req030_hold", 288'(link_fault), 288'(8'h01));
    idleCycles(1);
    checkOutput("req030_ok", 288'(link_fault), 288'(8'h00));
    data = rand_bits();
    applyStimulus(all_ch(IDLE2), data, 1'b0);
    checkOutput("req030_pass", tx_dc_out, data);

    $display("[TB] channel independence");
    applyStimulus(one_ch(2, LF2), rand_bits(), 1'b0);
    applyStimulus(one_ch(2, LF2), rand_bits(), 1'b0);
    checkOutput("req031_lf", 288'(link_fault), 288'(8'h10));
    data = rand_bits();
    applyStimulus(all_ch(IDLE2), data, 1'b0);
    checkOutput("req031_ch0", 288'(tx_dc_out[71:0]), 288'(data[71:0]));
    checkOutput("req031_ch1", 288'(tx_dc_out[143:72]), 288'(data[143:72]));
    checkOutput("req031_ch2", 288'(tx_dc_out[215:144]), 288'(RF2));
    checkOutput("req031_ch3", 288'(tx_dc_out[287:216]), 288'(data[287:216]));
    idleCycles(64);
    checkOutput("req031_clear", 288'(link_fault), 288'(8'h00));

    $display("[TB] fault episode counting and clear priority");
    doReset();
    for (int ep = 0; ep < 3; ep++) begin
      applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
      applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
      idleCycles(64);
    end
`ifdef XGMII_FAULT_STATS_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    checkOutput("req032_cnt", 288'(fault_cnt[15:0]), 288'(exp_cnt));
    applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
    applyStimulus(one_ch(0, LF2), rand_bits(), 1'b1);
    checkOutput("req032_clr", 288'(fault_cnt[15:0]), 288'(16'd0));
    checkOutput("req032_lf", 288'(link_fault), 288'(8'h01));

    $display("[TB] reset discards a partial sequence run");
    doReset();
    applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
    applyStimulus(one_ch(0, {IDLE_COL, LF_COL}), rand_bits(), 1'b0);
    doReset();
    applyStimulus(one_ch(0, {IDLE_COL, LF_COL}), rand_bits(), 1'b0);
    checkOutput("req033_ok", 288'(link_fault), 288'(8'h00));
    applyStimulus(one_ch(0, LF2), rand_bits(), 1'b0);
    checkOutput("req033_three", 288'(link_fault), 288'(8'h00));
    applyStimulus(one_ch(0, {IDLE_COL, LF_COL}), rand_bits(), 1'b0);
    checkOutput("req033_four", 288'(link_fault), 288'(8'h01));

    $display("[TB] randomized traffic");
    doReset();
    for (int ch = 0; ch < NCH; ch++) begin
      mode[ch] = 0;
      dur[ch]  = 0;
    end
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (dur[ch] == 0) begin
          mode[ch] = $urandom_range(0, 3);
          dur[ch]  = $urandom_range(10, 120);
        end
        dur[ch]--;
        rnd_rx[72*ch +: 72] = {rand_col(mode[ch]), rand_col(mode[ch])};
      end
      applyStimulus(rnd_rx, rand_bits(), ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xgmii_link_fault_rs.md
XGMII_LINK_FAULT_RS -- requirements
Module: xgmii_link_fault_rs

Interface
REQ-001 Parameter NUM_CH, default 1, meaning number of independent XGMII double-width channels, legal range 1..4.
REQ-002 Parameter COL_WINDOW, default 128, meaning the number of columns without a sequence ordered set after which the fault state clears, legal range 8..1024.
REQ-003 Parameter SEQ_THRESH, default 4, meaning the number of same-type sequence ordered sets needed to declare a fault, legal range 2..15.
REQ-004 Port xgmii_tx_clk, input, 1 bit, the single clock for all logic.
REQ-005 Port xgmii_tx_clk_reset, input, 1 bit, asynchronous active-high reset.
REQ-006 Port rx_dc_in, input, 72*NUM_CH bits, received XGMII double-width words per channel.
REQ-007 Port tx_dc_in, input, 72*NUM_CH bits, XGMII double-width words from the MAC per channel.
REQ-008 Port tx_dc_out, output, 72*NUM_CH bits, XGMII double-width words toward the PHY per channel.
REQ-009 Port link_fault, output, 2*NUM_CH bits, per-channel fault state: 00 OK, 01 LOCAL, 10 REMOTE.
REQ-010 Port fault_cnt, output, 16*NUM_CH bits, per-channel count of fault events.
REQ-011 Port fault_cnt_clr, input, 1 bit, synchronous clear of all fault_cnt values.

Function
REQ-012 The 72-bit word SHALL be decoded as 8 lanes of 9 bits, where lane k = bits [9k+8:9k], bit 8 is the control flag, and bits 7:0 are data; lanes 0-3 form column 0 (earlier in time) and lanes 4-7 form column 1.
REQ-013 A column SHALL qualify as a sequence ordered set only when all of the following hold: lane0 is control 0x9C; lanes 1 and 2 are data 0x00; lane3 is data 0x01 (local fault) or data 0x02 (remote fault).
REQ-014 Each channel SHALL hold a last_type register (LOCAL or REMOTE), a seq_cnt counter (4 bits, saturating at 15) and a col_cnt counter (saturating at COL_WINDOW).
REQ-015 Both columns SHALL be processed in time order within one cycle, applying these rules per column:
- Sequence column of the same type as last_type: seq_cnt increments and col_cnt clears.
- Sequence column of a different type: last_type is updated, seq_cnt becomes 1, and col_cnt clears.
- Any other column: col_cnt increments.
REQ-016 link_fault SHALL become last_type in the cycle after the cycle in which seq_cnt reaches SEQ_THRESH.
REQ-017 link_fault SHALL become OK, and seq_cnt SHALL clear to 0, in the cycle after the cycle in which col_cnt reaches COL_WINDOW.
REQ-018 When REQ-016 and REQ-017 are satisfied in the same cycle, the later column SHALL decide the result.
REQ-019 tx_dc_out SHALL be registered with a latency of exactly 1 cycle, selected by the registered link_fault value:
- OK: tx_dc_in is passed through unchanged.
- LOCAL: both columns are remote-fault sequence sets (9C, 00, 00, 02 on lanes 0-3, with only lane0 flagged as control).
- REMOTE: all 8 lanes are control 0x07 (idle).
REQ-020 A change of link_fault SHALL take effect on tx_dc_out in the next cycle, and SHALL never split a 72-bit word.
REQ-021 Channels SHALL be fully independent, with no cross-channel state.

Reset
REQ-022 While xgmii_tx_clk_reset is high, every channel SHALL hold link_fault=00, last_type=LOCAL, seq_cnt=0, col_cnt=0 and fault_cnt=0.
REQ-023 While xgmii_tx_clk_reset is high, tx_dc_out SHALL be idle columns (all lanes control 0x07).
REQ-024 Reset asserted in the middle of a sequence run SHALL discard the partial count, so that after release SEQ_THRESH fresh sequence sets are needed to declare a fault.

Configuration
REQ-025 When XGMII_FAULT_STATS_EN is defined, each fault_cnt SHALL increment by 1 on every transition of its link_fault from OK to non-OK, saturating at 0xFFFF.
REQ-026 When XGMII_FAULT_STATS_EN is defined, fault_cnt_clr SHALL zero all counters on the next clock edge and SHALL take priority over a same-cycle increment.
REQ-027 When XGMII_FAULT_STATS_EN is not defined, fault_cnt SHALL be constant 0, fault_cnt_clr SHALL be ignored, and no counter logic SHALL be synthesised.

Verification
REQ-028 With NUM_CH=1, 4 consecutive local-fault columns on rx_dc_in SHALL produce link_fault=01, after which tx_dc_out SHALL carry 9C/00/00/02 columns one cycle later.
REQ-029 From the LOCAL state, 2 remote-fault columns followed by 2 local-fault columns SHALL leave the state at LOCAL, and 4 remote-fault columns SHALL then produce link_fault=10 with tx_dc_out all 0x07.
REQ-030 From the LOCAL state, 128 idle columns (64 cycles) SHALL produce link_fault=00, and data on tx_dc_in SHALL reappear on tx_dc_out with 1-cycle latency.
REQ-031 With NUM_CH=4, a fault injected on channel 2 only SHALL change link_fault[5:4] alone, and the other channels SHALL pass through unchanged.
REQ-032 With XGMII_FAULT_STATS_EN defined, 3 fault episodes SHALL yield fault_cnt=3, and asserting fault_cnt_clr together with a new fault SHALL yield 0.
REQ-033 Asserting reset after 3 local-fault columns, releasing it, and then sending 1 more local-fault column SHALL leave link_fault=00.
